coin_acceptor: RTL and testbench

Parametrised coin acceptor front end and the successor to the fixed three-coin detector. It measures each coinSensor pulse with a saturating width counter and classifies the width against per-denomination windows. It flags out-of-window pulses as rejects and detects jams (sensor held too long). It also keeps a saturating credit total that the vend controller clears through creditClr.

---
 rtl/coin_acceptor.sv | 169 ++++++++++++++++
 tb/tb_coin_acceptor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: measures synchronised sensor pulse widths,
// classifies them into dime/nickel/quarter/reject, detects jams, keeps credit.
module coin_acceptor #(
   parameter int CNT_W    = 8,
   parameter int CREDIT_W = 8,
   parameter int D_MIN    = 2,
   parameter int D_MAX    = 4,
   parameter int N_MIN    = 6,
   parameter int N_MAX    = 8,
   parameter int Q_MIN    = 10,
   parameter int Q_MAX    = 12,
   parameter int D_VAL    = 10,
   parameter int N_VAL    = 5,
   parameter int Q_VAL    = 25,
   parameter int JAM_LIM  = 20
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coinSensor,
   input  logic                creditClr,
   output logic                dimeDetected,
   output logic                nickelDetected,
   output logic                quarterDetected,
   output logic                rejectDetected,
   output logic                jam,
   output logic [CREDIT_W-1:0] credit,
   output logic                creditOvf
);

   typedef enum logic [1:0] {IDLE, MEASURE, JAM} state_t;

   localparam logic [CNT_W-1:0] D_LO = CNT_W'(D_MIN);
   localparam logic [CNT_W-1:0] D_HI = CNT_W'(D_MAX);
   localparam logic [CNT_W-1:0] N_LO = CNT_W'(N_MIN);
   localparam logic [CNT_W-1:0] N_HI = CNT_W'(N_MAX);
   localparam logic [CNT_W-1:0] Q_LO = CNT_W'(Q_MIN);
   localparam logic [CNT_W-1:0] Q_HI = CNT_W'(Q_MAX);
   localparam logic [CNT_W-1:0] J_LIM = CNT_W'(JAM_LIM);
   localparam logic [CREDIT_W:0] C_MAX = {1'b0, {CREDIT_W{1'b1}}};

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                sync1_q, s_q;
   logic                dime_q, dime_d;
   logic                nick_q, nick_d;
   logic                quar_q, quar_d;
   logic                rej_q, rej_d;
   logic                jam_q, jam_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                ovf_q, ovf_d;

   logic                meas_end, in_d, in_n, in_q, add;
   logic [CREDIT_W-1:0] add_val;
   logic [CREDIT_W:0]   sum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
      end else begin
         sync1_q <= coinSensor;
         s_q     <= sync1_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (s_q) begin
               cnt_d   = CNT_W'(1);
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (s_q) begin
               if (cnt_q == J_LIM) state_d = JAM;
               else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         JAM: begin
            if (!s_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Window priority: dime over nickel over quarter.
   always_comb begin
      meas_end = (state_q == MEASURE) && !s_q;
      in_d     = (cnt_q >= D_LO) && (cnt_q <= D_HI);
      in_n     = (cnt_q >= N_LO) && (cnt_q <= N_HI);
      in_q     = (cnt_q >= Q_LO) && (cnt_q <= Q_HI);
      dime_d   = meas_end && in_d;
      nick_d   = meas_end && !in_d && in_n;
      quar_d   = meas_end && !in_d && !in_n && in_q;
      rej_d    = meas_end && !(in_d || in_n || in_q);
      jam_d    = (state_d == JAM);
      add      = dime_d || nick_d || quar_d;
      add_val  = '0;
      if (dime_d)      add_val = CREDIT_W'(D_VAL);
      else if (nick_d) add_val = CREDIT_W'(N_VAL);
      else if (quar_d) add_val = CREDIT_W'(Q_VAL);
      sum      = {1'b0, credit_q} + {1'b0, add_val};
      credit_d = credit_q;
      ovf_d    = ovf_q;
      if (creditClr) begin
         credit_d = add ? add_val : '0;
         ovf_d    = 1'b0;
      end else if (add) begin
         if (sum > C_MAX) begin
            credit_d = '1;
            ovf_d    = 1'b1;
         end else begin
            credit_d = sum[CREDIT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dime_q   <= 1'b0;
         nick_q   <= 1'b0;
         quar_q   <= 1'b0;
         rej_q    <= 1'b0;
         jam_q    <= 1'b0;
         credit_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         dime_q   <= dime_d;
         nick_q   <= nick_d;
         quar_q   <= quar_d;
         rej_q    <= rej_d;
         jam_q    <= jam_d;
         credit_q <= credit_d;
         ovf_q    <= ovf_d;
      end
   end

   assign dimeDetected    = dime_q;
   assign nickelDetected  = nick_q;
   assign quarterDetected = quar_q;
   assign rejectDetected  = rej_q;
   assign jam             = jam_q;
   assign credit          = credit_q;
   assign creditOvf       = ovf_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: classification, latency, credit
// saturation and clear, jam handling, back-to-back pulses, mid-pulse reset.
module tb_coin_acceptor;

   logic       clk = 1'b0;
   logic       reset;
   logic       coinSensor;
   logic       creditClr;
   logic       dimeDetected, nickelDetected, quarterDetected;
   logic       rejectDetected, jam, creditOvf;
   logic [7:0] credit;

   int checks   = 0;
   int failures = 0;

   coin_acceptor dut (
      .clk             (clk),
      .reset           (reset),
      .coinSensor      (coinSensor),
      .creditClr       (creditClr),
      .dimeDetected    (dimeDetected),
      .nickelDetected  (nickelDetected),
      .quarterDetected (quarterDetected),
      .rejectDetected  (rejectDetected),
      .jam             (jam),
      .credit          (credit),
      .creditOvf       (creditOvf)
   );

   always #5 clk = ~clk;

   // Sensor high across exactly n rising edges, then low.
   task automatic drive_pulse(input int n);
      @(negedge clk);
      coinSensor = 1'b1;
      repeat (n) @(negedge clk);
      coinSensor = 1'b0;
   endtask

   task automatic observe(output int nd, output int nn, output int nq,
                          output int nr, output int first);
      nd = 0; nn = 0; nq = 0; nr = 0; first = -1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (dimeDetected || nickelDetected || quarterDetected || rejectDetected)
            if (first < 0) first = i;
         if (dimeDetected)    nd++;
         if (nickelDetected)  nn++;
         if (quarterDetected) nq++;
         if (rejectDetected)  nr++;
      end
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      creditClr = 1'b1;
      @(negedge clk);
      creditClr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; coinSensor = 1'b0; creditClr = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({dimeDetected, nickelDetected, quarterDetected, rejectDetected,
           jam, creditOvf} !== 6'b0 || credit !== 8'd0) begin
         failures++;
         $display("FAIL reset_state: flags=%b credit=%0d required 0/0",
                  {dimeDetected, nickelDetected, quarterDetected,
                   rejectDetected, jam, creditOvf}, credit);
      end
      reset = 1'b0;
   endtask

   task automatic test_first_dime();
      int nd, nn, nq, nr, first;
      drive_pulse(3);
      observe(nd, nn, nq, nr, first);
      checks++;
      if (nd !== 1 || nn !== 0 || nq !== 0 || nr !== 0) begin
         failures++;
         $display("FAIL first_dime_class: d=%0d n=%0d q=%0d r=%0d required 1/0/0/0",
                  nd, nn, nq, nr);
      end
      checks++;
      if (first !== 3) begin
         failures++;
         $display("FAIL first_dime_latency: cycle=%0d required 3", first);
      end
      checks++;
      if (credit !== 8'd10 || creditOvf !== 1'b0 || jam !== 1'b0) begin
         failures++;
         $display("FAIL first_dime_credit: credit=%0d ovf=%b jam=%b required 10/0/0",
                  credit, creditOvf, jam);
      end
   endtask

   task automatic test_widths();
      int w[11]    = '{2, 4, 6, 8, 10, 12, 1, 5, 9, 13, 20};
      int kind[11] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3};
      int expc[11] = '{20, 30, 35, 40, 65, 90, 90, 90, 90, 90, 90};
      int nd, nn, nq, nr, first;
      for (int i = 0; i < 11; i++) begin
         drive_pulse(w[i]);
         observe(nd, nn, nq, nr, first);
         checks++;
         if (nd !== int'(kind[i] == 0) || nn !== int'(kind[i] == 1) ||
             nq !== int'(kind[i] == 2) || nr !== int'(kind[i] == 3) ||
             first !== 3) begin
            failures++;
            $display("FAIL width_%0d: d=%0d n=%0d q=%0d r=%0d at=%0d required kind %0d at 3",
                     w[i], nd, nn, nq, nr, first, kind[i]);
         end
         checks++;
         if (credit !== 8'(expc[i])) begin
            failures++;
            $display("FAIL width_%0d_credit: credit=%0d required %0d",
                     w[i], credit, expc[i]);
         end
      end
   endtask

   task automatic test_saturation();
      int expc[11] = '{25, 50, 75, 100, 125, 150, 175, 200, 225, 250, 255};
      int nd, nn, nq, nr, first;
      clr_pulse();
      checks++;
      if (credit !== 8'd0) begin
         failures++;
         $display("FAIL sat_preclear: credit=%0d required 0", credit);
      end
      for (int i = 0; i < 11; i++) begin
         drive_pulse(11);
         observe(nd, nn, nq, nr, first);
         checks++;
         if (nq !== 1 || credit !== 8'(expc[i]) ||
             creditOvf !== (i == 10)) begin
            failures++;
            $display("FAIL sat_quarter_%0d: q=%0d credit=%0d ovf=%b required 1/%0d/%b",
                     i + 1, nq, credit, creditOvf, expc[i], (i == 10));
         end
      end
      clr_pulse();
      checks++;
      if (credit !== 8'd0 || creditOvf !== 1'b0) begin
         failures++;
         $display("FAIL sat_clear: credit=%0d ovf=%b required 0/0",
                  credit, creditOvf);
      end
   endtask

   task automatic test_jam();
      int rise = -1, fall = -1, pulses = 0;
      int nd, nn, nq, nr, first;
      @(negedge clk);
      coinSensor = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (jam && rise < 0) rise = k;
         if (dimeDetected || nickelDetected || quarterDetected || rejectDetected)
            pulses++;
      end
      coinSensor = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (!jam && fall < 0) fall = k;
         if (dimeDetected || nickelDetected || quarterDetected || rejectDetected)
            pulses++;
      end
      checks++;
      if (rise !== 23) begin
         failures++;
         $display("FAIL jam_rise: edge=%0d required 23", rise);
      end
      checks++;
      if (fall !== 3) begin
         failures++;
         $display("FAIL jam_clear: cycle=%0d required 3", fall);
      end
      checks++;
      if (pulses !== 0 || credit !== 8'd0) begin
         failures++;
         $display("FAIL jam_quiet: pulses=%0d credit=%0d required 0/0",
                  pulses, credit);
      end
      drive_pulse(3);
      observe(nd, nn, nq, nr, first);
      checks++;
      if (nd !== 1 || nr !== 0 || credit !== 8'd10) begin
         failures++;
         $display("FAIL jam_then_dime: d=%0d r=%0d credit=%0d required 1/0/10",
                  nd, nr, credit);
      end
   endtask

   task automatic test_clr_coincide();
      int nd, nn, nq, nr, first;
      clr_pulse();
      for (int i = 0; i < 4; i++) begin
         drive_pulse(3);
         observe(nd, nn, nq, nr, first);
      end
      checks++;
      if (credit !== 8'd40) begin
         failures++;
         $display("FAIL coincide_setup: credit=%0d required 40", credit);
      end
      drive_pulse(7);
      @(negedge clk);
      @(negedge clk);
      creditClr = 1'b1;
      @(negedge clk);
      creditClr = 1'b0;
      checks++;
      if (nickelDetected !== 1'b1 || credit !== 8'd5 || creditOvf !== 1'b0) begin
         failures++;
         $display("FAIL coincide_clear: nickel=%b credit=%0d ovf=%b required 1/5/0",
                  nickelDetected, credit, creditOvf);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int nd = 0, nr = 0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         coinSensor = (i < 3) || (i >= 4 && i < 7);
         @(negedge clk);
         if (dimeDetected)   nd++;
         if (rejectDetected) nr++;
      end
      checks++;
      if (nd !== 2 || nr !== 0 || credit !== 8'd25) begin
         failures++;
         $display("FAIL back_to_back: dimes=%0d rejects=%0d credit=%0d required 2/0/25",
                  nd, nr, credit);
      end
   endtask

   task automatic test_reset_mid();
      int nd, nn, nq, nr, first;
      @(negedge clk);
      coinSensor = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (credit !== 8'd0 || jam !== 1'b0) begin
         failures++;
         $display("FAIL midreset_state: credit=%0d jam=%b required 0/0",
                  credit, jam);
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      coinSensor = 1'b0;
      observe(nd, nn, nq, nr, first);
      checks++;
      if (nd !== 1 || nn !== 0 || nq !== 0 || nr !== 0 || credit !== 8'd10) begin
         failures++;
         $display("FAIL midreset_dime: d=%0d n=%0d q=%0d r=%0d credit=%0d required 1/0/0/0/10",
                  nd, nn, nq, nr, credit);
      end
   endtask

   initial begin
      test_reset();
      test_first_dime();
      test_widths();
      test_saturation();
      test_jam();
      test_clr_coincide();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
